// File: rtl/mem_port_arbiter.sv
// Byte-serial memory port arbiter: round-robin over request channels,
// splits 1/2/4-byte accesses into byte beats, assembles load data.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int IO_SEL_HI = 17
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        clear_in,
  input  logic                        io_buffer_full,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [ADDR_W-1:0]           mem_a,
  output logic                        mem_wr,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [2*NUM_PORTS-1:0]      req_size,
  input  logic [NUM_PORTS-1:0]        req_signed,
  input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [32*NUM_PORTS-1:0]     req_wdata,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [31:0]                 rsp_data
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [PW-1:0] RR_RST = PW'(NUM_PORTS-1);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, DONE
  } state_e;

  state_e state_q, state_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] g_q, g_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [23:0] rbuf_q, rbuf_d;
  logic [1:0] size_q, size_d;
  logic sgn_q, sgn_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic wr_q, wr_d;
  logic [NUM_PORTS-1:0] rsp_q, rsp_d;

  logic [NUM_PORTS-1:0] elig;
  logic found;
  logic [PW-1:0] pick;
  logic [2:0] nbeats;
  logic [ADDR_W-1:0] next_a;
  logic [31:0] ldata;
  logic ext;

  // IO stores are held back while the UART buffer is full
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = req_valid[i] & ~(req_we[i] & io_buffer_full &
        (req_addr[i*ADDR_W+IO_SEL_HI -: 2] == 2'b11));
    end
  end

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = rr_q;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    nbeats = 3'd4;
    if (size_q == 2'd0) nbeats = 3'd1;
    if (size_q == 2'd1) nbeats = 3'd2;
  end

  assign next_a = addr_q + ADDR_W'(cnt_q);
  assign ext    = sgn_q & mem_din[7];

  always_comb begin
    ldata = {mem_din, rbuf_q};
    case (size_q)
      2'd0:    ldata = {{24{ext}}, mem_din};
      2'd1:    ldata = {{16{ext}}, mem_din, rbuf_q[7:0]};
      default: ldata = {mem_din, rbuf_q};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    g_d        = g_q;
    addr_d     = addr_q;
    mem_a_d    = mem_a_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rbuf_d     = rbuf_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    wr_d       = wr_q;
    rsp_d      = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (!clear_in && found) begin
          g_d     = pick;
          rr_d    = pick;
          addr_d  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
          mem_a_d = req_addr[int'(pick)*ADDR_W +: ADDR_W];
          size_d  = req_size[int'(pick)*2 +: 2];
          sgn_d   = req_signed[pick];
          wdata_d = req_wdata[int'(pick)*32 +: 32];
          cnt_d   = 3'd1;
          if (req_we[pick]) begin
            state_d = WRITE;
            dout_d  = req_wdata[int'(pick)*32 +: 8];
            wr_d    = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (clear_in) begin
          state_d = IDLE;
        end else if (cnt_q == nbeats) begin
          rsp_data_d = ldata;
          rsp_d[g_q] = 1'b1;
          state_d    = DONE;
        end else begin
          case (cnt_q)
            3'd1:    rbuf_d[7:0]   = mem_din;
            3'd2:    rbuf_d[15:8]  = mem_din;
            default: rbuf_d[23:16] = mem_din;
          endcase
          mem_a_d = next_a;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      WRITE: begin
        if (cnt_q == nbeats) begin
          wr_d       = 1'b0;
          rsp_d[g_q] = 1'b1;
          state_d    = DONE;
        end else begin
          case (cnt_q)
            3'd1:    dout_d = wdata_q[15:8];
            3'd2:    dout_d = wdata_q[23:16];
            default: dout_d = wdata_q[31:24];
          endcase
          mem_a_d = next_a;
          wr_d    = 1'b1;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      DONE: begin
        rsp_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      rr_q       <= RR_RST;
      g_q        <= '0;
      addr_q     <= '0;
      mem_a_q    <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rbuf_q     <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      cnt_q      <= '0;
      dout_q     <= '0;
      wr_q       <= 1'b0;
      rsp_q      <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      g_q        <= g_d;
      addr_q     <= addr_d;
      mem_a_q    <= mem_a_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rbuf_q     <= rbuf_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      rsp_q      <= rsp_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = dout_q;
  assign mem_wr    = wr_q & rdy_in;
  assign rsp_valid = rsp_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte RAM model, write log,
// hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [3:0]  req_size;
  logic [1:0]  req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  ram [0:4095];
  logic [31:0] wr_a [$];
  logic [7:0]  wr_b [$];

  mem_port_arbiter #(
    .NUM_PORTS(2), .ADDR_W(32), .IO_SEL_HI(17)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .clear_in(clear_in), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk_in = ~clk_in;

  assign mem_din = ram[mem_a[11:0]];

  always @(posedge clk_in) begin
    if (mem_wr) begin
      wr_a.push_back(mem_a);
      wr_b.push_back(mem_dout);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (rsp_valid == 2'b00 && n < 40);
  endtask

  task automatic set_port(input int p, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd);
    req_we[p]          = we;
    req_size[2*p +: 2] = sz;
    req_signed[p]      = sg;
    req_addr[32*p +: 32]  = a;
    req_wdata[32*p +: 32] = wd;
  endtask

  task automatic do_req(input int p, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, output int n,
                        output logic [31:0] d, output logic [1:0] v);
    set_port(p, we, sz, sg, a, wd);
    req_valid[p] = 1'b1;
    wait_rsp(n);
    d = rsp_data;
    v = rsp_valid;
    req_valid[p] = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int p;
    logic [31:0] d;
    logic [1:0] v;
    logic [1:0] seen;

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22;
    ram[12'h102] = 8'h33; ram[12'h103] = 8'h80;
    ram[12'h104] = 8'hFF; ram[12'h105] = 8'h7F;
    ram[12'hFFE] = 8'h01; ram[12'hFFF] = 8'h02;
    ram[12'h000] = 8'h03; ram[12'h001] = 8'h04;

    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    io_buffer_full = 1'b0;
    req_valid = '0; req_we = '0; req_size = '0; req_signed = '0;
    req_addr = '0; req_wdata = '0;
    step(); step();
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_dout", {24'h0, mem_dout}, 32'h0);
    check("rst_wr", {31'h0, mem_wr}, 32'h0);
    check("rst_rsp", {30'h0, rsp_valid}, 32'h0);
    check("rst_data", rsp_data, 32'h0);
    rst_in = 1'b1;
    step();

    // word load, latency and assembly
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, n, d, v);
    check("wload_lat", n, 5);
    check("wload_v", {30'h0, v}, 32'h2);
    check("wload_d", d, 32'h80332211);
    check("wload_done", {30'h0, rsp_valid}, 32'h0);

    do_req(1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, n, d, v);
    check("sbyte_lat", n, 2);
    check("sbyte_d", d, 32'hFFFFFF80);
    do_req(1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, n, d, v);
    check("ubyte_d", d, 32'h00000080);
    do_req(1, 1'b0, 2'd1, 1'b1, 32'h104, 32'h0, n, d, v);
    check("shalf_lat", n, 3);
    check("shalf_d", d, 32'h00007FFF);
    do_req(1, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, n, d, v);
    check("size3_lat", n, 5);
    check("size3_d", d, 32'h80332211);
    do_req(1, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, n, d, v);
    check("wrap_d", d, 32'h04030201);

    // round-robin with both ports requesting
    set_port(0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
    set_port(1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_rsp(n);
      check("arb_lat", n, 2);
      check("arb_grant", {30'h0, rsp_valid}, (t % 2 == 0) ? 32'h1 : 32'h2);
      check("arb_d", rsp_data, (t % 2 == 0) ? 32'h11 : 32'h22);
      p = rsp_valid[1] ? 1 : 0;
      req_valid[p] = 1'b0;
      step();
      req_valid[p] = 1'b1;
    end
    req_valid = 2'b00;
    step();

    // IO store held while buffer full, loads still served
    wr_a.delete(); wr_b.delete();
    io_buffer_full = 1'b1;
    set_port(1, 1'b1, 2'd0, 1'b0, 32'h30000, 32'hA5);
    set_port(0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
    req_valid = 2'b11;
    for (int t = 0; t < 2; t++) begin
      wait_rsp(n);
      check("io_load_v", {30'h0, rsp_valid}, 32'h1);
      req_valid[0] = 1'b0;
      step();
      req_valid[0] = (t == 0);
    end
    step(); step();
    check("io_hold", wr_a.size(), 0);
    io_buffer_full = 1'b0;
    wait_rsp(n);
    check("io_st_lat", n, 2);
    check("io_st_v", {30'h0, rsp_valid}, 32'h2);
    req_valid = 2'b00;
    step();
    check("io_wr_cnt", wr_a.size(), 1);
    if (wr_a.size() == 1) begin
      check("io_wr_a", wr_a[0], 32'h30000);
      check("io_wr_b", {24'h0, wr_b[0]}, 32'hA5);
    end

    // flush during the second beat of a word load
    set_port(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    req_valid[1] = 1'b1;
    step(); step();
    clear_in = 1'b1;
    req_valid[1] = 1'b0;
    step();
    clear_in = 1'b0;
    seen = rsp_valid;
    for (int t = 0; t < 4; t++) begin
      step();
      seen = seen | rsp_valid;
    end
    check("clr_no_rsp", {30'h0, seen}, 32'h0);
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, n, d, v);
    check("clr_idle_lat", n, 2);
    check("clr_after_d", d, 32'h22);

    // rdy_in low for three cycles in the middle of a store
    wr_a.delete(); wr_b.delete();
    set_port(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'hDDCCBBAA);
    req_valid[0] = 1'b1;
    step(); step();
    rdy_in = 1'b0;
    #1;
    check("rdy_wr_gate", {31'h0, mem_wr}, 32'h0);
    step(); step(); step();
    check("rdy_hold_a", mem_a, 32'h201);
    check("rdy_hold_b", {24'h0, mem_dout}, 32'hBB);
    rdy_in = 1'b1;
    wait_rsp(n);
    check("rdy_lat", n, 3);
    req_valid[0] = 1'b0;
    step();
    check("rdy_wr_cnt", wr_a.size(), 4);
    if (wr_a.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("rdy_wr_a", wr_a[k], 32'h200 + k);
        check("rdy_wr_b", {24'h0, wr_b[k]}, 32'hAA + 32'h11 * k);
      end
    end

    // async reset in the middle of a store
    set_port(0, 1'b1, 2'd2, 1'b0, 32'h300, 32'h44332211);
    req_valid[0] = 1'b1;
    step(); step();
    rst_in = 1'b0;
    req_valid = 2'b00;
    #1;
    check("arst_wr", {31'h0, mem_wr}, 32'h0);
    check("arst_a", mem_a, 32'h0);
    check("arst_dout", {24'h0, mem_dout}, 32'h0);
    check("arst_rsp", {30'h0, rsp_valid}, 32'h0);
    check("arst_data", rsp_data, 32'h0);
    step();
    set_port(0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
    set_port(1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
    req_valid = 2'b11;
    rst_in = 1'b1;
    wait_rsp(n);
    check("arst_first", {30'h0, rsp_valid}, 32'h1);
    check("arst_first_d", rsp_data, 32'h11);
    req_valid = 2'b00;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
